// File: rtl/multimemory_arbiter.sv
// Shares one single-port synchronous RAM among REQUESTERS read/write ports; read data is routed back by tag.
// Optional: define MULTIMEMORY_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module multimemory_arbiter #(
    parameter int REQUESTERS = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] r_addr,
    input  logic [REQUESTERS-1:0]            r_avalid,
    output logic [REQUESTERS-1:0]            r_aready,
    output logic [REQUESTERS-1:0]            r_dvalid,
    output logic [REQUESTERS*DATA_WIDTH-1:0] r_data,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] w_addr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] w_data,
    input  logic [REQUESTERS-1:0]            w_valid,
    output logic [REQUESTERS-1:0]            w_ready,
    output logic                             m_en,
    output logic                             m_we,
    output logic [ADDR_WIDTH-1:0]            m_addr,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic [DATA_WIDTH-1:0]            m_rdata
);
    localparam int IDX_W = $clog2(REQUESTERS);

    logic [REQUESTERS-1:0] w_req;
    logic                  w_gnt_any;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic                  w_active;
    logic                  w_gnt_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic [ADDR_WIDTH-1:0] r_maddr;
    logic [DATA_WIDTH-1:0] r_mwdata;
    logic                  r_tag_v;
    logic [IDX_W-1:0]      r_tag_idx;

    assign w_req = r_avalid | w_valid;

`ifdef MULTIMEMORY_ARB_FIXED_PRIO_EN
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (w_req[k]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IDX_W'(k);
            end
        end
    end
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQUESTERS - 1);

    logic [IDX_W-1:0] r_ptr;

    // Offsets are scanned high to low so the requester nearest the pointer is the last one written.
    always_comb begin
        int cand;
        cand      = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            cand = int'(r_ptr) + k;
            if (cand >= REQUESTERS) begin
                cand = cand - REQUESTERS;
            end
            if (w_req[cand[IDX_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_active) begin
            r_ptr <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
        end
    end
`endif

    assign w_active    = w_gnt_any & rst;
    assign w_gnt_wr    = w_valid[w_gnt_idx];
    assign w_sel_addr  = w_gnt_wr ? w_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH]
                                  : r_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = w_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        r_aready = '0;
        w_ready  = '0;
        if (w_active) begin
            if (w_gnt_wr) begin
                w_ready[w_gnt_idx] = 1'b1;
            end else begin
                r_aready[w_gnt_idx] = 1'b1;
            end
        end
    end

    // Address and write data hold their last driven value while the RAM is idle.
    assign m_en    = w_active;
    assign m_we    = w_active & w_gnt_wr;
    assign m_addr  = w_active ? w_sel_addr : r_maddr;
    assign m_wdata = (w_active & w_gnt_wr) ? w_sel_wdata : r_mwdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_maddr   <= '0;
            r_mwdata  <= '0;
            r_tag_v   <= 1'b0;
            r_tag_idx <= '0;
            r_dvalid  <= '0;
            r_data    <= '0;
        end else begin
            if (w_active) begin
                r_maddr <= w_sel_addr;
            end
            if (w_active & w_gnt_wr) begin
                r_mwdata <= w_sel_wdata;
            end
            r_tag_v   <= w_active & ~w_gnt_wr;
            r_tag_idx <= w_gnt_idx;
            // Second tag stage: RAM output is valid now and lands in the issuing requester's slot.
            for (int i = 0; i < REQUESTERS; i++) begin
                r_dvalid[i] <= r_tag_v && (r_tag_idx == IDX_W'(i));
                if (r_tag_v && (r_tag_idx == IDX_W'(i))) begin
                    r_data[i*DATA_WIDTH +: DATA_WIDTH] <= m_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_multimemory_arbiter.sv
// Directed bench for multimemory_arbiter: RAM environment, grant/return model checked every cycle, literal checks per scenario.
module tb_multimemory_arbiter;
    localparam int R  = 3;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int QD = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [R*AW-1:0] r_addr;
    logic [R-1:0]    r_avalid;
    logic [R-1:0]    r_aready;
    logic [R-1:0]    r_dvalid;
    logic [R*DW-1:0] r_data;
    logic [R*AW-1:0] w_addr;
    logic [R*DW-1:0] w_data;
    logic [R-1:0]    w_valid;
    logic [R-1:0]    w_ready;
    logic            m_en;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;

    always #5 clk = ~clk;

    multimemory_arbiter #(.REQUESTERS(R), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
        .r_dvalid(r_dvalid), .r_data(r_data),
        .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // RAM environment: one-cycle registered read
    logic [DW-1:0] ram [65536];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            else      m_rdata <= ram[m_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    ret_t          rnew;
    logic [DW-1:0] mem_m [65536];
    logic [DW-1:0] exp_rd [R];
    int            ptr_m = 0;
    int            eg = -1;
    int            cc;
    bit            eg_wr;
    logic [AW-1:0] eg_addr, last_addr;
    logic [DW-1:0] eg_data, last_wdata;
    logic [R-1:0]  ea, ew, edv;
    logic [R*DW-1:0] epk;

    // observation logs
    int            glog_idx[$];
    bit            glog_wr[$];
    int            glog_cyc[$];
    int            rlog_idx[$];
    logic [DW-1:0] rlog_data[$];
    int            rlog_cyc[$];
    int            gobs;

    // protocol history
    bit            p_ok = 1'b0;
    logic [R-1:0]  p_rv, p_ra, p_wv, p_wr;
    logic [R*AW-1:0] p_raddr, p_waddr;
    logic [R*DW-1:0] p_wdata;

    bit hs_r [R];
    bit hs_w [R];

    always @(negedge clk) begin
        ea = '0; ew = '0; edv = '0; eg = -1; eg_wr = 1'b0;
        if (!rst) begin
            ptr_m = 0;
            rq.delete();
            last_addr  = '0;
            last_wdata = '0;
            for (int i = 0; i < R; i++) exp_rd[i] = '0;
        end else begin
            for (int k = 0; k < R; k++) begin
`ifdef MULTIMEMORY_ARB_FIXED_PRIO_EN
                cc = k;
`else
                cc = (ptr_m + k) % R;
`endif
                if (eg < 0 && (r_avalid[cc] || w_valid[cc])) eg = cc;
            end
            if (eg >= 0) begin
                eg_wr = w_valid[eg];
                if (eg_wr) begin
                    ew[eg]  = 1'b1;
                    eg_addr = w_addr[eg*AW +: AW];
                    eg_data = w_data[eg*DW +: DW];
                end else begin
                    ea[eg]  = 1'b1;
                    eg_addr = r_addr[eg*AW +: AW];
                end
            end
            while (rq.size() > 0 && rq[0].due <= cyc) begin
                if (rq[0].due == cyc) begin
                    edv[rq[0].idx]    = 1'b1;
                    exp_rd[rq[0].idx] = rq[0].data;
                end
                void'(rq.pop_front());
            end
        end
        for (int i = 0; i < R; i++) epk[i*DW +: DW] = exp_rd[i];

        chk("r_aready", r_aready, ea);
        chk("w_ready", w_ready, ew);
        chk("m_en", m_en, eg >= 0);
        chk("m_we", m_we, eg_wr);
        chk("m_addr", m_addr, (eg >= 0) ? eg_addr : last_addr);
        if (eg_wr || eg < 0) chk("m_wdata", m_wdata, eg_wr ? eg_data : last_wdata);
        chk("r_dvalid", r_dvalid, edv);
        chk("r_data", r_data, epk);

        gobs = -1;
        for (int i = 0; i < R; i++) begin
            hs_r[i] = r_avalid[i] & r_aready[i];
            hs_w[i] = w_valid[i] & w_ready[i];
            if (gobs < 0 && (r_aready[i] || w_ready[i])) gobs = i;
        end
        if (gobs >= 0) begin
            glog_idx.push_back(gobs);
            glog_wr.push_back(w_ready[gobs]);
            glog_cyc.push_back(cyc);
            $display("txn cyc=%0d req=%0d %s addr=%h", cyc, gobs, w_ready[gobs] ? "WR" : "RD", m_addr);
        end
        for (int i = 0; i < R; i++) begin
            if (r_dvalid[i]) begin
                rlog_idx.push_back(i);
                rlog_data.push_back(r_data[i*DW +: DW]);
                rlog_cyc.push_back(cyc);
                $display("rsp cyc=%0d req=%0d data=%h", cyc, i, r_data[i*DW +: DW]);
            end
        end

        if (rst && p_ok) begin
            for (int i = 0; i < R; i++) begin
                if (p_rv[i] && !p_ra[i])
                    chk("proto_rd", {r_avalid[i], r_addr[i*AW +: AW]}, {1'b1, p_raddr[i*AW +: AW]});
                if (p_wv[i] && !p_wr[i])
                    chk("proto_wr", {w_valid[i], w_addr[i*AW +: AW], w_data[i*DW +: DW]},
                        {1'b1, p_waddr[i*AW +: AW], p_wdata[i*DW +: DW]});
            end
        end
        p_ok = rst; p_rv = r_avalid; p_ra = r_aready; p_wv = w_valid; p_wr = w_ready;
        p_raddr = r_addr; p_waddr = w_addr; p_wdata = w_data;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst && eg >= 0) begin
            last_addr = eg_addr;
            ptr_m     = (eg + 1) % R;
            if (eg_wr) begin
                mem_m[eg_addr] = eg_data;
                last_wdata     = eg_data;
            end else begin
                rnew.due  = cyc + 1;
                rnew.idx  = eg;
                rnew.data = mem_m[eg_addr];
                rq.push_back(rnew);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [AW-1:0] rd_tab [R][QD];
    logic [AW-1:0] wa_tab [R][QD];
    logic [DW-1:0] wd_tab [R][QD];
    int rd_n [R];
    int rd_h [R];
    int wr_n [R];
    int wr_h [R];

    task automatic drive();
        for (int i = 0; i < R; i++) begin
            r_avalid[i] = rd_h[i] < rd_n[i];
            w_valid[i]  = wr_h[i] < wr_n[i];
            r_addr[i*AW +: AW] = r_avalid[i] ? rd_tab[i][rd_h[i]] : '0;
            w_addr[i*AW +: AW] = w_valid[i] ? wa_tab[i][wr_h[i]] : '0;
            w_data[i*DW +: DW] = w_valid[i] ? wd_tab[i][wr_h[i]] : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < R; i++) begin
            if (hs_r[i]) rd_h[i]++;
            if (hs_w[i]) wr_h[i]++;
            hs_r[i] = 1'b0;
            hs_w[i] = 1'b0;
        end
        drive();
    endtask

    task automatic clear_q();
        for (int i = 0; i < R; i++) begin
            rd_n[i] = 0; rd_h[i] = 0; wr_n[i] = 0; wr_h[i] = 0;
            hs_r[i] = 1'b0; hs_w[i] = 1'b0;
        end
        drive();
    endtask

    task automatic do_reset();
        clear_q();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    function automatic bit idle();
        bit b;
        b = (rq.size() == 0);
        for (int i = 0; i < R; i++) b = b && (rd_h[i] >= rd_n[i]) && (wr_h[i] >= wr_n[i]);
        return b;
    endfunction

    task automatic run(input string nm, input int maxc);
        for (int c = 0; c < maxc; c++) begin
            step();
            if (idle()) break;
        end
        chk({nm, "_done"}, idle(), 1'b1);
    endtask

    int g0, r0, c0;
    int exp_g [9];
    int exp_g6 [8];

    initial begin
        for (int a = 0; a < 65536; a++) begin
            ram[a]   = DW'(a);
            mem_m[a] = DW'(a);
        end
        rst = 1'b0;
        clear_q();
        #1;
        step();
        step();
        rst = 1'b1;

        // single requester, back-to-back reads
        g0 = glog_idx.size(); r0 = rlog_idx.size();
        for (int k = 0; k < 3; k++) rd_tab[0][k] = AW'(16'h0010 + k);
        rd_n[0] = 3;
        drive();
        run("s1", 40);
        chk("s1_ngrant", glog_idx.size() - g0, 3);
        chk("s1_nrsp", rlog_idx.size() - r0, 3);
        for (int k = 0; k < 3; k++) begin
            if (glog_idx.size() > g0 + k && rlog_idx.size() > r0 + k) begin
                chk("s1_gidx", glog_idx[g0+k], 0);
                chk("s1_gcyc", glog_cyc[g0+k] - glog_cyc[g0], k);
                chk("s1_ridx", rlog_idx[r0+k], 0);
                chk("s1_data", rlog_data[r0+k], 16'h0010 + k);
                chk("s1_lat", rlog_cyc[r0+k] - glog_cyc[g0+k], 2);
            end
        end

        // all three contending
        do_reset();
        g0 = glog_idx.size(); r0 = rlog_idx.size();
        for (int i = 0; i < R; i++) begin
            for (int k = 0; k < 3; k++) rd_tab[i][k] = AW'(16'h0010 + 16'h0100 * i);
            rd_n[i] = 3;
        end
        for (int k = 0; k < 9; k++) begin
`ifdef MULTIMEMORY_ARB_FIXED_PRIO_EN
            exp_g[k] = k / 3;
`else
            exp_g[k] = k % 3;
`endif
        end
        drive();
        run("s2", 60);
        chk("s2_ngrant", glog_idx.size() - g0, 9);
        chk("s2_nrsp", rlog_idx.size() - r0, 9);
        for (int k = 0; k < 9; k++) begin
            if (glog_idx.size() > g0 + k) chk("s2_gidx", glog_idx[g0+k], exp_g[k]);
            if (rlog_idx.size() > r0 + k)
                chk("s2_data", rlog_data[r0+k], 16'h0010 + 16'h0100 * rlog_idx[r0+k]);
        end

        // write from 0 and read from 2 to the same address, same cycle
        do_reset();
        g0 = glog_idx.size(); r0 = rlog_idx.size();
        wa_tab[0][0] = 16'h0212; wd_tab[0][0] = 16'hA012; wr_n[0] = 1;
        rd_tab[2][0] = 16'h0212; rd_n[2] = 1;
        drive();
        run("s3", 30);
        chk("s3_ngrant", glog_idx.size() - g0, 2);
        chk("s3_nrsp", rlog_idx.size() - r0, 1);
        if (glog_idx.size() >= g0 + 2 && rlog_idx.size() >= r0 + 1) begin
            chk("s3_g0", {glog_idx[g0], glog_wr[g0]}, {32'd0, 1'b1});
            chk("s3_g1", {glog_idx[g0+1], glog_wr[g0+1]}, {32'd2, 1'b0});
            chk("s3_gap", glog_cyc[g0+1] - glog_cyc[g0], 1);
            chk("s3_ridx", rlog_idx[r0], 2);
            chk("s3_data", rlog_data[r0], 16'hA012);
        end

        // same requester write + read together
        do_reset();
        g0 = glog_idx.size(); r0 = rlog_idx.size();
        wa_tab[1][0] = 16'h0300; wd_tab[1][0] = 16'h1234; wr_n[1] = 1;
        rd_tab[1][0] = 16'h0300; rd_n[1] = 1;
        drive();
        run("s4", 30);
        chk("s4_ngrant", glog_idx.size() - g0, 2);
        if (glog_idx.size() >= g0 + 2 && rlog_idx.size() >= r0 + 1) begin
            chk("s4_g0", {glog_idx[g0], glog_wr[g0]}, {32'd1, 1'b1});
            chk("s4_g1", {glog_idx[g0+1], glog_wr[g0+1]}, {32'd1, 1'b0});
            chk("s4_gap", glog_cyc[g0+1] - glog_cyc[g0], 1);
            chk("s4_data", rlog_data[r0], 16'h1234);
        end

        // reset the cycle after a read handshake
        do_reset();
        g0 = glog_idx.size(); r0 = rlog_idx.size();
        rd_tab[1][0] = 16'h0020; rd_n[1] = 1;
        drive();
        step();
        chk("s5_hs", glog_idx.size() - g0, 1);
        clear_q();
        rst = 1'b0;
        step();
        step();
        step();
        chk("s5_no_rsp", rlog_idx.size() - r0, 0);
        rst = 1'b1;
        g0 = glog_idx.size();
        rd_tab[2][0] = 16'h0030; rd_n[2] = 1;
        drive();
        c0 = cyc;
        run("s5", 20);
        chk("s5_ngrant", glog_idx.size() - g0, 1);
        chk("s5_nrsp", rlog_idx.size() - r0, 1);
        if (glog_idx.size() > g0 && rlog_idx.size() > r0) begin
            chk("s5_gidx", glog_idx[g0], 2);
            chk("s5_gcyc", glog_cyc[g0], c0);
            chk("s5_ridx", rlog_idx[r0], 2);
            chk("s5_data", rlog_data[r0], 16'h0030);
        end

        // sustained requests from all three, requester 0 deepest
        do_reset();
        g0 = glog_idx.size();
        for (int k = 0; k < 6; k++) rd_tab[0][k] = AW'(16'h0040 + k);
        rd_n[0] = 6;
        rd_tab[1][0] = 16'h0050; rd_n[1] = 1;
        rd_tab[2][0] = 16'h0060; rd_n[2] = 1;
        for (int k = 0; k < 8; k++) begin
`ifdef MULTIMEMORY_ARB_FIXED_PRIO_EN
            exp_g6[k] = (k < 6) ? 0 : k - 5;
`else
            exp_g6[k] = (k < 3) ? k : 0;
`endif
        end
        drive();
        run("s6", 40);
        chk("s6_ngrant", glog_idx.size() - g0, 8);
        for (int k = 0; k < 8; k++) begin
            if (glog_idx.size() > g0 + k) chk("s6_gidx", glog_idx[g0+k], exp_g6[k]);
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
